// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair of the MIPS core with an iterative
// radix-2 restoring divider for DIV/DIVU.
//
// Ports
//   clk, resetn           core clock, asynchronous active-low reset
//   mul_we, alu_hi/lo     MULT/MULTU result write (HI and LO)
//   mthi_we, mtlo_we      MTHI/MTLO writes of wdata
//   div_start/signed/a/b  DIV/DIVU request from EX (taken only in IDLE)
//   flush                 aborts a divide, blocks a start
//   stall_o               pipeline stall while a divide is accepted/running
//   div_busy_o            divider not in IDLE
//   hi_o, lo_o            current HI/LO registers (no write bypass)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no divide; HI/LO take MULT/MTHI/MTLO writes; accepts start
// BUSY  | one restoring step per cycle, DATA_W steps in total
// DONE  | sign-correct quotient/remainder and write LO/HI, then IDLE

module hilo_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mul_we,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic [DATA_W-1:0] alu_lo,
  input  logic              mthi_we,
  input  logic              mtlo_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_a,
  input  logic [DATA_W-1:0] div_b,
  input  logic              flush,
  output logic              stall_o,
  output logic              div_busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] dq_q, dq_d;    // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W:0]   rem_shift, rem_diff;
  logic              rem_ge;
  logic [DATA_W-1:0] q_fix, r_fix;
  logic              div_wr;

  always_comb begin
    a_abs = (div_signed && div_a[DATA_W-1]) ? -div_a : div_a;
    b_abs = (div_signed && div_b[DATA_W-1]) ? -div_b : div_b;
    rem_shift = {rem_q[DATA_W-1:0], dq_q[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    rem_ge    = (rem_shift >= {1'b0, dvs_q});
    // A zero divisor naturally yields quotient all-ones and remainder = dividend.
    q_fix = q_neg_q ? -dq_q : dq_q;
    r_fix = r_neg_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    stall_o = 1'b0;
    div_wr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_start && !flush) begin
          state_d = BUSY;
          stall_o = 1'b1;
          cnt_d   = '0;
          rem_d   = '0;
          dq_d    = a_abs;
          dvs_d   = b_abs;
          q_neg_d = div_signed & (div_a[DATA_W-1] ^ div_b[DATA_W-1]);
          r_neg_d = div_signed & div_a[DATA_W-1];
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          rem_d   = rem_ge ? rem_diff : rem_shift;
          dq_d    = {dq_q[DATA_W-2:0], rem_ge};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) state_d = DONE;
        end
      end
      DONE: begin
        // stall_o low here so the DIV leaves EX on the writing edge.
        state_d = IDLE;
        div_wr  = !flush;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_wr) begin
      hi_d = r_fix;
      lo_d = q_fix;
    end else if (mul_we) begin
      hi_d = alu_hi;
      lo_d = alu_lo;
    end else begin
      if (mthi_we) hi_d = wdata;
      if (mtlo_we) lo_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign div_busy_o = (state_q != IDLE);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
